// File: rtl/print_hex_pkg.sv
// Shared definitions for the print_hex block.
// Contents:
//   state_e           - controller state encoding (IDLE, ARM, WAIT_ACK, WAIT_DONE)
//   ASCII_CR/LF       - line terminator codes appended after the digits
//   ASCII_DIGIT_BASE  - code of '0', base for nibbles 0x0..0x9
//   ASCII_LETTER_BASE - code of 'A', base for nibbles 0xA..0xF
package print_hex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARM       = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_CR          = 8'h0D;
  localparam logic [7:0] ASCII_LF          = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT_BASE  = 8'h30;
  localparam logic [7:0] ASCII_LETTER_BASE = 8'h41;

endpackage

// File: rtl/print_hex_hex_to_ascii.sv
// hex_to_ascii: purely combinational nibble to uppercase ASCII converter.
// Ports:
//   nibble - 4-bit value 0x0..0xF
//   ascii  - 8-bit code, '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
module hex_to_ascii
  import print_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_DIGIT_BASE + {4'd0, nibble};
    end else begin
      // Offset from 'A': nibble 0xA maps to the letter base itself.
      ascii = ASCII_LETTER_BASE + {4'd0, nibble - 4'd10};
    end
  end

endmodule

// File: rtl/print_hex.sv
// print_hex: prints one word as DIGITS uppercase hex characters (most
// significant nibble first), optionally followed by CR LF, through a
// byte-wide handshake toward a UART transmitter.
// Ports:
//   clk     - single clock, rising edge
//   rstn    - synchronous active-low reset
//   vld_in  - producer word request; accepted when vld_in && rdy_in
//   din     - word to print (4*DIGITS bits), sampled on accept
//   rdy_in  - registered; 1 = idle, able to accept a word
//   vld_tx  - registered; character valid toward the transmitter
//   d_tx    - registered; ASCII character toward the transmitter
//   rdy_tx  - transmitter ready; 1 = transmitter idle
// Handshake per character: ARM waits for rdy_tx=1 and raises vld_tx,
// WAIT_ACK holds it until the transmitter goes busy (rdy_tx=0), WAIT_DONE
// waits for the transmitter to become idle again before the next character.
module print_hex
  import print_hex_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int APPEND_CRLF = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  vld_in,
  input  logic [4*DIGITS-1:0]   din,
  output logic                  rdy_in,
  output logic                  vld_tx,
  output logic [7:0]            d_tx,
  input  logic                  rdy_tx
);

  localparam int         W       = 4 * DIGITS;
  localparam int         TAIL    = (APPEND_CRLF != 0) ? 2 : 0;
  localparam logic [3:0] TOTAL_C = 4'(DIGITS + TAIL);

  state_e         state, state_nx;
  logic [W-1:0]   shreg, shreg_nx;
  logic [3:0]     cnt, cnt_nx;
  logic           rdy_in_nx;
  logic           vld_tx_nx;
  logic [7:0]     d_tx_nx;
  logic [7:0]     digit_char;
  logic [7:0]     cur_char;

  // The character to send is always the top nibble of the shift register;
  // the count tells when the digits are exhausted and CR/LF follow.
  hex_to_ascii u_hex_to_ascii (
    .nibble (shreg[W-1 -: 4]),
    .ascii  (digit_char)
  );

  always_comb begin
    cur_char = digit_char;
    if (TAIL != 0 && cnt == 4'd2) begin
      cur_char = ASCII_CR;
    end else if (TAIL != 0 && cnt == 4'd1) begin
      cur_char = ASCII_LF;
    end
  end

  // NOTE: every signal written here gets its default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    cnt_nx    = cnt;
    rdy_in_nx = rdy_in;
    vld_tx_nx = vld_tx;
    d_tx_nx   = d_tx;

    case (state)
      ST_IDLE: begin
        rdy_in_nx = 1'b1;
        vld_tx_nx = 1'b0;
        if (vld_in && rdy_in) begin
          shreg_nx  = din;
          cnt_nx    = TOTAL_C;
          rdy_in_nx = 1'b0;
          state_nx  = ST_ARM;
        end
      end

      ST_ARM: begin
        // d_tx is only ever loaded here, so it cannot move while vld_tx=1.
        d_tx_nx = cur_char;
        if (rdy_tx) begin
          vld_tx_nx = 1'b1;
          state_nx  = ST_WAIT_ACK;
        end else begin
          vld_tx_nx = 1'b0;
        end
      end

      ST_WAIT_ACK: begin
        // No timeout: a transmitter that never goes busy keeps us here.
        if (!rdy_tx) begin
          vld_tx_nx = 1'b0;
          state_nx  = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        vld_tx_nx = 1'b0;
        if (rdy_tx) begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) begin
            // Last character done: rdy_in rises only now, never earlier.
            rdy_in_nx = 1'b1;
            state_nx  = ST_IDLE;
          end else begin
            shreg_nx = shreg << 4;
            state_nx = ST_ARM;
          end
        end
      end

      default: begin
        rdy_in_nx = 1'b1;
        vld_tx_nx = 1'b0;
        state_nx  = ST_IDLE;
      end
    endcase
  end

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      // NOTE: the shift register is a plain register, not a memory array,
      // so clearing it on reset is cheap and leaves no stale digits behind.
      shreg  <= '0;
      cnt    <= '0;
      rdy_in <= 1'b1;
      vld_tx <= 1'b0;
      d_tx   <= '0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      cnt    <= cnt_nx;
      rdy_in <= rdy_in_nx;
      vld_tx <= vld_tx_nx;
      d_tx   <= d_tx_nx;
    end
  end

endmodule

// File: tb/tb_print_hex.sv
// Bench for print_hex: two instances (8 digits + CRLF, and 2 digits without
// CRLF), each feeding a behavioural 8N1 UART transmitter at 16 clocks/bit
// whose serial line is decoded back into bytes and compared against
// hand-written expected strings.
module tb_print_hex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;

  // Channel 0: DIGITS=8, APPEND_CRLF=1
  logic        vld_in0 = 1'b0;
  logic [31:0] din0 = '0;
  logic        rdy_in0, vld_tx0, rdy_tx0;
  logic [7:0]  d_tx0;
  logic        force_busy0 = 1'b0;

  // Channel 1: DIGITS=2, APPEND_CRLF=0
  logic        vld_in1 = 1'b0;
  logic [7:0]  din1 = '0;
  logic        rdy_in1, vld_tx1, rdy_tx1;
  logic [7:0]  d_tx1;
  logic        force_busy1 = 1'b0;

  print_hex #(.DIGITS(8), .APPEND_CRLF(1)) dut0 (
    .clk(clk), .rstn(rstn), .vld_in(vld_in0), .din(din0), .rdy_in(rdy_in0),
    .vld_tx(vld_tx0), .d_tx(d_tx0), .rdy_tx(rdy_tx0)
  );

  print_hex #(.DIGITS(2), .APPEND_CRLF(0)) dut1 (
    .clk(clk), .rstn(rstn), .vld_in(vld_in1), .din(din1), .rdy_in(rdy_in1),
    .vld_tx(vld_tx1), .d_tx(d_tx1), .rdy_tx(rdy_tx1)
  );

  // ---------------- behavioural UART transmitters -------------------------
  logic [1:0] tx_busy = '0;
  int         tx_tick [2] = '{0, 0};
  logic [9:0] tx_frame [2];
  logic [1:0] tx_vld;
  logic [7:0] tx_data [2];
  logic       txd [2];

  assign tx_vld     = {vld_tx1, vld_tx0};
  assign tx_data[0] = d_tx0;
  assign tx_data[1] = d_tx1;
  assign rdy_tx0    = ~tx_busy[0] & ~force_busy0;
  assign rdy_tx1    = ~tx_busy[1] & ~force_busy1;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!tx_busy[c]) begin
        if (tx_vld[c]) begin
          tx_busy[c]  <= 1'b1;
          tx_frame[c] <= {1'b1, tx_data[c], 1'b0};
          tx_tick[c]  <= 0;
        end
      end else if (tx_tick[c] == 159) begin
        tx_busy[c] <= 1'b0;
      end else begin
        tx_tick[c] <= tx_tick[c] + 1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      txd[c] = tx_busy[c] ? tx_frame[c][tx_tick[c] / 16] : 1'b1;
    end
  end

  // ---------------- serial line decoders ----------------------------------
  logic [1:0] rx_busy = '0;
  int         rx_tick [2] = '{0, 0};
  logic [7:0] rx_sh [2];
  int         frame_err = 0;
  logic [7:0] rxq0 [$];
  logic [7:0] rxq1 [$];

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rx_busy[c]) begin
        if (!txd[c]) begin
          rx_busy[c] <= 1'b1;
          rx_tick[c] <= 0;
        end
      end else begin
        rx_tick[c] <= rx_tick[c] + 1;
        // Sample data bits near their middle, LSB first.
        if (rx_tick[c] >= 23 && rx_tick[c] <= 135 && ((rx_tick[c] - 23) % 16) == 0)
          rx_sh[c] <= {txd[c], rx_sh[c][7:1]};
        if (rx_tick[c] == 151) begin
          rx_busy[c] <= 1'b0;
          if (!txd[c]) frame_err <= frame_err + 1;
          if (c == 0) rxq0.push_back(rx_sh[c]);
          else        rxq1.push_back(rx_sh[c]);
        end
      end
    end
  end

  // ---------------- d_tx stability monitor --------------------------------
  int         stab_err = 0;
  logic       prev_vld0 = 1'b0, prev_vld1 = 1'b0;
  logic [7:0] prev_d0 = '0, prev_d1 = '0;

  always @(negedge clk) begin
    if (prev_vld0 && vld_tx0 && d_tx0 !== prev_d0) stab_err <= stab_err + 1;
    if (prev_vld1 && vld_tx1 && d_tx1 !== prev_d1) stab_err <= stab_err + 1;
    prev_vld0 <= vld_tx0;
    prev_d0   <= d_tx0;
    prev_vld1 <= vld_tx1;
    prev_d1   <= d_tx1;
  end

  // ---------------- bookkeeping -------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic wait_rdy(input int ch, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((ch == 0 && rdy_in0) || (ch == 1 && rdy_in1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic build_expected(input string s, input bit crlf, output logic [7:0] e [$]);
    e.delete();
    for (int i = 0; i < s.len(); i++) e.push_back(8'(s[i]));
    if (crlf) begin
      e.push_back(8'h0D);
      e.push_back(8'h0A);
    end
  endtask

  // ---------------- tests -------------------------------------------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    total++; if (rdy_in0 !== 1'b1) begin bad++; $display("FAIL reset_rdy_in0: got %b want 1", rdy_in0); end
    total++; if (vld_tx0 !== 1'b0) begin bad++; $display("FAIL reset_vld_tx0: got %b want 0", vld_tx0); end
    total++; if (d_tx0 !== 8'h00) begin bad++; $display("FAIL reset_d_tx0: got %02h want 00", d_tx0); end
    total++; if (rdy_in1 !== 1'b1) begin bad++; $display("FAIL reset_rdy_in1: got %b want 1", rdy_in1); end
    total++; if (vld_tx1 !== 1'b0) begin bad++; $display("FAIL reset_vld_tx1: got %b want 0", vld_tx1); end
    total++; if (d_tx1 !== 8'h00) begin bad++; $display("FAIL reset_d_tx1: got %02h want 00", d_tx1); end
  endtask

  task automatic test_word();
    logic [7:0] e [$];
    bit ok;
    build_expected("1234ABCD", 1'b1, e);
    rxq0.delete();
    @(negedge clk);
    vld_in0 = 1'b1;
    din0    = 32'h1234ABCD;
    @(negedge clk);            // accept edge has passed
    vld_in0 = 1'b0;
    din0    = 32'hDEADBEEF;
    total++; if (rdy_in0 !== 1'b0) begin bad++; $display("FAIL word_rdy_drop: got %b want 0", rdy_in0); end
    total++; if (vld_tx0 !== 1'b0) begin bad++; $display("FAIL word_vld_early: got %b want 0", vld_tx0); end
    @(negedge clk);            // second edge after the request
    total++; if (vld_tx0 !== 1'b1) begin bad++; $display("FAIL word_latency: vld_tx got %b want 1", vld_tx0); end
    total++; if (d_tx0 !== 8'h31) begin bad++; $display("FAIL word_first_char: got %02h want 31", d_tx0); end
    wait_rdy(0, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL word_timeout: rdy_in never rose"); end
    total++; if (rxq0.size() != 10) begin bad++; $display("FAIL word_frames: got %0d want 10", rxq0.size()); end
    for (int i = 0; i < e.size(); i++) begin
      total++;
      if (rxq0[i] !== e[i]) begin bad++; $display("FAIL word_char[%0d]: got %02h want %02h", i, rxq0[i], e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e0 [$];
    logic [7:0] e1 [$];
    bit ok;
    build_expected("00000000", 1'b1, e0);
    build_expected("FFFFFFFF", 1'b1, e1);
    rxq0.delete();
    @(negedge clk);
    vld_in0 = 1'b1;
    din0    = 32'h00000000;
    @(negedge clk);
    total++; if (rdy_in0 !== 1'b0) begin bad++; $display("FAIL b2b_first_accept: rdy_in got %b want 0", rdy_in0); end
    din0 = 32'hFFFFFFFF;       // change while busy, vld_in still high
    wait_rdy(0, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout1: rdy_in never rose"); end
    total++; if (rxq0.size() != 10) begin bad++; $display("FAIL b2b_frames1: got %0d want 10", rxq0.size()); end
    @(negedge clk);
    total++; if (rdy_in0 !== 1'b0) begin bad++; $display("FAIL b2b_second_accept: rdy_in got %b want 0", rdy_in0); end
    vld_in0 = 1'b0;
    wait_rdy(0, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout2: rdy_in never rose"); end
    total++; if (rxq0.size() != 20) begin bad++; $display("FAIL b2b_frames2: got %0d want 20", rxq0.size()); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (rxq0[i] !== e0[i]) begin bad++; $display("FAIL b2b_w0_char[%0d]: got %02h want %02h", i, rxq0[i], e0[i]); end
      total++;
      if (rxq0[i+10] !== e1[i]) begin bad++; $display("FAIL b2b_w1_char[%0d]: got %02h want %02h", i, rxq0[i+10], e1[i]); end
    end
  endtask

  task automatic test_two_digits();
    bit ok;
    rxq1.delete();
    @(negedge clk);
    vld_in1 = 1'b1;
    din1    = 8'h5E;
    @(negedge clk);
    vld_in1 = 1'b0;
    wait_rdy(1, 1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL two_timeout: rdy_in never rose"); end
    repeat (400) @(negedge clk);
    total++; if (rxq1.size() != 2) begin bad++; $display("FAIL two_frames: got %0d want 2", rxq1.size()); end
    total++; if (rxq1[0] !== 8'h35) begin bad++; $display("FAIL two_char0: got %02h want 35", rxq1[0]); end
    total++; if (rxq1[1] !== 8'h45) begin bad++; $display("FAIL two_char1: got %02h want 45", rxq1[1]); end
  endtask

  task automatic test_stall();
    bit ok;
    int early;
    early = 0;
    rxq1.delete();
    @(negedge clk);
    force_busy1 = 1'b1;
    vld_in1     = 1'b1;
    din1        = 8'hA7;
    @(negedge clk);
    vld_in1 = 1'b0;
    total++; if (rdy_in1 !== 1'b0) begin bad++; $display("FAIL stall_accept: rdy_in got %b want 0", rdy_in1); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (vld_tx1 !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL stall_vld_while_busy: got %0d cycles want 0", early); end
    force_busy1 = 1'b0;
    @(negedge clk);
    total++; if (vld_tx1 !== 1'b1) begin bad++; $display("FAIL stall_release: vld_tx got %b want 1", vld_tx1); end
    total++; if (d_tx1 !== 8'h41) begin bad++; $display("FAIL stall_char: got %02h want 41", d_tx1); end
    wait_rdy(1, 1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: rdy_in never rose"); end
    repeat (20) @(negedge clk);
    total++; if (rxq1.size() != 2) begin bad++; $display("FAIL stall_frames: got %0d want 2", rxq1.size()); end
    total++; if (rxq1[0] !== 8'h41 || rxq1[1] !== 8'h37) begin
      bad++; $display("FAIL stall_bytes: got %02h %02h want 41 37", rxq1[0], rxq1[1]);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] e [$];
    bit ok;
    bit found;
    int resumed;
    build_expected("00000009", 1'b1, e);
    found   = 1'b0;
    resumed = 0;
    @(negedge clk);
    vld_in0 = 1'b1;
    din0    = 32'h1234ABCD;
    @(negedge clk);
    vld_in0 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (vld_tx0 && d_tx0 == 8'h33) begin found = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL rmid_third_char: never presented"); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    total++; if (vld_tx0 !== 1'b0) begin bad++; $display("FAIL rmid_vld: got %b want 0", vld_tx0); end
    total++; if (rdy_in0 !== 1'b1) begin bad++; $display("FAIL rmid_rdy_in: got %b want 1", rdy_in0); end
    total++; if (d_tx0 !== 8'h00) begin bad++; $display("FAIL rmid_d_tx: got %02h want 00", d_tx0); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (vld_tx0 !== 1'b0 || rdy_in0 !== 1'b1) resumed++;
    end
    total++; if (resumed != 0) begin bad++; $display("FAIL rmid_resume: got %0d active cycles want 0", resumed); end
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!tx_busy[0] && !rx_busy[0]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (!ok) begin bad++; $display("FAIL rmid_line_idle: transmitter still busy"); end
    repeat (5) @(negedge clk);
    rxq0.delete();
    vld_in0 = 1'b1;
    din0    = 32'h00000009;
    @(negedge clk);
    vld_in0 = 1'b0;
    wait_rdy(0, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_timeout: rdy_in never rose"); end
    total++; if (rxq0.size() != 10) begin bad++; $display("FAIL rmid_frames: got %0d want 10", rxq0.size()); end
    for (int i = 0; i < e.size(); i++) begin
      total++;
      if (rxq0[i] !== e[i]) begin bad++; $display("FAIL rmid_char[%0d]: got %02h want %02h", i, rxq0[i], e[i]); end
    end
  endtask

  task automatic test_line_integrity();
    total++; if (stab_err != 0) begin bad++; $display("FAIL d_tx_stable: got %0d changes want 0", stab_err); end
    total++; if (frame_err != 0) begin bad++; $display("FAIL stop_bits: got %0d bad stops want 0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_back_to_back();
    test_two_digits();
    test_stall();
    test_reset_mid_word();
    test_line_integrity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
